// File: rtl/ghash_core.sv
`default_nettype none
// ============================================================================
//  Module   : ghash_core
//  Purpose  : GHASH accumulator for AES-GCM. Each accepted block X_i updates
//             Y <= (Y ^ X_i) * H in GF(2^128) using a bit-serial (or 4-bit
//             digit-serial) shift-and-add multiplier.
//  Build    : define GHASH_DIGIT4_EN for 4 bits/cycle (32-cycle multiply);
//             default is 1 bit/cycle (128-cycle multiply). y_out is
//             bit-identical in both builds.
//  Ports    : clk, rst_n (async, active-low)
//             h_in/h_valid    - hash subkey load strobe
//             blk_in/blk_valid/blk_ready - block handshake
//             clear           - restart hash (Y <= 0)
//             y_out, done     - accumulator and single-cycle update pulse
//             h_loaded, busy  - status
//  Revision : 1.0 - initial release
// ============================================================================
module ghash_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] h_in,
    input  logic         h_valid,
    input  logic [127:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         clear,
    output logic [127:0] y_out,
    output logic         done,
    output logic         h_loaded,
    output logic         busy
);

`ifdef GHASH_DIGIT4_EN
    localparam int unsigned C_DIGIT = 4;
    localparam int unsigned C_CNT_W = 5;
`else
    localparam int unsigned C_DIGIT = 1;
    localparam int unsigned C_CNT_W = 7;
`endif

    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in reflected bit order.
    localparam logic [127:0] C_R = {8'hE1, 120'd0};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [127:0]         h_q, h_d;
    logic [127:0]         hp_q, hp_d;
    logic                 h_pend_q, h_pend_d;
    logic                 h_loaded_q, h_loaded_d;
    logic [127:0]         y_q, y_d;
    logic [127:0]         x_q, x_d;
    logic [127:0]         z_q, z_d;
    logic [127:0]         v_q, v_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 done_q, done_d;

    logic [127:0]         m_x, m_z, m_v;
    logic                 accept;

    // One multiplier step of C_DIGIT bits. X is consumed MSB-first by
    // shifting it left, so bit 127 is always the next coefficient.
    always_comb begin
        m_x = x_q;
        m_z = z_q;
        m_v = v_q;
        for (int i = 0; i < C_DIGIT; i++) begin
            if (m_x[127]) begin
                m_z = m_z ^ m_v;
            end
            m_v = m_v[0] ? ((m_v >> 1) ^ C_R) : (m_v >> 1);
            m_x = m_x << 1;
        end
    end

    // A pending or arriving H and a clear must all settle before a new block.
    assign blk_ready = (state_q == ST_IDLE) && h_loaded_q && !clear
                       && !h_valid && !h_pend_q;
    assign accept    = blk_ready && blk_valid;

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        hp_d       = hp_q;
        h_pend_d   = h_pend_q;
        h_loaded_d = h_loaded_q;
        y_d        = y_q;
        x_d        = x_q;
        z_d        = z_q;
        v_d        = v_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (h_valid) begin
                    h_d        = h_in;
                    y_d        = '0;
                    h_loaded_d = 1'b1;
                    h_pend_d   = 1'b0;
                end else if (h_pend_q) begin
                    // Deferred key change lands one edge after done so the
                    // done-cycle result stays visible.
                    h_d      = hp_q;
                    y_d      = '0;
                    h_pend_d = 1'b0;
                end
                if (clear) begin
                    y_d = '0;
                end
                if (accept) begin
                    x_d     = y_q ^ blk_in;
                    z_d     = '0;
                    v_d     = h_q;
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end
            end
            ST_MULT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                    if (h_valid) begin
                        h_d        = h_in;
                        h_loaded_d = 1'b1;
                        h_pend_d   = 1'b0;
                    end
                end else begin
                    if (h_valid) begin
                        hp_d     = h_in;
                        h_pend_d = 1'b1;
                    end
                    x_d   = m_x;
                    z_d   = m_z;
                    v_d   = m_v;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {C_CNT_W{1'b1}}) begin
                        y_d     = m_z;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            h_q        <= '0;
            hp_q       <= '0;
            h_pend_q   <= 1'b0;
            h_loaded_q <= 1'b0;
            y_q        <= '0;
            x_q        <= '0;
            z_q        <= '0;
            v_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            hp_q       <= hp_d;
            h_pend_q   <= h_pend_d;
            h_loaded_q <= h_loaded_d;
            y_q        <= y_d;
            x_q        <= x_d;
            z_q        <= z_d;
            v_q        <= v_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    assign y_out    = y_q;
    assign done     = done_q;
    assign h_loaded = h_loaded_q;
    assign busy     = (state_q == ST_MULT);

endmodule
`default_nettype wire

// File: doc/ghash_core.md
GHASH_CORE -- requirements
Module: ghash_core

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 h_in  input  128  hash subkey H from the subkey generator, GCM bit order (bit 127 = x^0).
REQ-004 h_valid  input  1  single-cycle strobe; h_in is valid this cycle.
REQ-005 blk_in  input  128  data block X_i (AAD, ciphertext or length block).
REQ-006 blk_valid  input  1  blk_in is offered.
REQ-007 blk_ready  output  1  block accepted on a clk edge where blk_valid && blk_ready.
REQ-008 clear  input  1  synchronous request: Y <= 0, start a new hash.
REQ-009 y_out  output  128  running GHASH accumulator Y.
REQ-010 done  output  1  single-cycle pulse; y_out holds the updated Y this cycle.
REQ-011 h_loaded  output  1  an H has been captured since reset.
REQ-012 busy  output  1  multiply in progress (state MULT).

Function
REQ-013 States are IDLE and MULT; reset enters IDLE.
REQ-014 blk_ready SHALL be 1 only in IDLE && h_loaded && !clear && !h_valid && !h_pend.
REQ-015 On accept: X <= y_out ^ blk_in, Z <= 0, V <= H, cnt <= 0, enter MULT.
REQ-016 Each MULT cycle processes D bits of X, MSB (bit 127) first; per bit: if the X bit = 1, Z ^= V; then V <= V[0] ? (V >> 1) ^ R : V >> 1, with R = 0xE1 followed by 120 zero bits.
REQ-017 Latency, D=1: 128 MULT cycles; on the edge ending cycle 128, Y <= Z, done = 1 for the next cycle, state = IDLE.
REQ-018 Block accepted at edge k gives done high in the cycle after edge k+N, where N = 128/D; blk_ready may rise in that same done cycle.
REQ-019 h_valid in IDLE: H <= h_in, Y <= 0, h_loaded <= 1; this wins over a simultaneous blk_valid, which is not accepted.
REQ-020 h_valid in MULT: h_in stored in a pending register with h_pend = 1; the current multiply completes using the old H.
REQ-021 A later h_valid in MULT overwrites the pending value.
REQ-022 Pending H is applied on the edge after done (H <= pending, Y <= 0, h_pend <= 0), so the done-cycle y_out is still observable.
REQ-023 clear in IDLE: Y <= 0 on the next edge; a simultaneous blk_valid is not accepted.
REQ-024 clear in MULT: multiply aborts, Y <= 0, state = IDLE, no done pulse; any pending H is retained and applied on the following edge.
REQ-025 clear together with h_valid: both take effect; H <= h_in, Y <= 0.
REQ-026 Blocks offered before any H is loaded stall; blk_ready stays 0 and there is no error.
REQ-027 blk_in is sampled only at the accept edge; the source may change it afterwards.

Reset
REQ-028 rst_n low SHALL asynchronously set:
- state = IDLE
- H, pending H, Y, X, Z, V, cnt = 0
- h_loaded, h_pend, done, busy, blk_ready = 0
REQ-029 Reset during MULT discards the multiply; no done pulse follows the release of rst_n.

Configuration
REQ-030 Macro GHASH_DIGIT4_EN: when defined, D = 4 bits per cycle, N = 32, cnt is 5 bits; when undefined, D = 1, N = 128, cnt is 7 bits.
REQ-031 y_out values SHALL be bit-identical in both builds; only latency and blk_ready timing differ.

Verification
REQ-032 Load H = 0x8000...0000 (multiplicative identity), send blk_in = 0x0123456789abcdef0011223344556677 -> y_out equals blk_in at done, after exactly N cycles.
REQ-033 Load H = 66e94bd4ef8a2c3b884cfa59ca342b2e, send blk_in = 0388dace60b6a392f328c2b971b2fe78 -> y_out = 5e2ec746917062882c85b0685353deb7.
REQ-034 Continue from REQ-033 with length block 0...0080 -> y_out matches the software GHASH model; blk_ready is low for exactly N cycles per block.
REQ-035 Pulse h_valid with a new H midway through MULT -> done reports the old-H result; next edge y_out = 0 and the new H is used for the following block.
REQ-036 Assert clear at MULT cycle 10 -> no done pulse, y_out = 0, blk_ready = 1 on the next cycle.
REQ-037 Deassert rst_n mid-MULT -> all outputs 0 immediately; h_loaded = 0 and blocks stall until a new h_valid.
